rr_program_scheduler: RTL
=========================

Name: rr_program_scheduler

Overview:
- Preemptive round-robin scheduler for the multi-program processor. Generalises the single-quantum program switch to NUM_PROG slots with a runtime-programmable quantum.
- Keeps a per-slot saved-PC table and an active mask. Counts retired instructions and, on quantum expiry or program end, picks the next active slot.
- Hands the PC unit a restore PC through a req/ack handshake.
- Sits between the control unit (quantum, end and retire strobes) and the PC unit (consumes the switch request).

Parameters:
NUM_PROG, 4, number of program slots (2..16)
ADDR_W, 32, PC width
QUANTUM_W, 16, quantum counter width
DEFAULT_QUANTUM, 100, quantum loaded at reset (nonzero)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
slot_load  in  1  pulse: register slot_pc as start PC of slot_id and mark the slot active
slot_id  in  $clog2(NUM_PROG)  slot index for slot_load
slot_pc  in  ADDR_W  start PC for slot_load
start  in  1  pulse: begin scheduling from the lowest-index active slot
instr_retired  in  1  one-cycle pulse per executed instruction
def_quantum  in  1  pulse: load quantum_in as the new quantum
quantum_in  in  QUANTUM_W  new quantum; 0 is treated as 1
end_program  in  1  pulse: the running program has halted
cur_pc  in  ADDR_W  live PC of the running program, sampled at preemption
switch_ack  in  1  PC unit has taken new_pc
switch_req  out  1  change-program request, held until acked
new_pc  out  ADDR_W  PC to load, stable while switch_req=1
new_id  out  $clog2(NUM_PROG)  slot being granted
running  out  1  a slot is executing (state RUN)
all_done  out  1  no active slots remain after start
active_mask  out  NUM_PROG  per-slot active flags
quantum_left  out  QUANTUM_W  remaining instructions in the current slice

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, PC table 0, quantum register = DEFAULT_QUANTUM.
- States: IDLE, SAVE, SELECT, GRANT, RUN, DONE.
- IDLE:
  - slot_load writes the table and sets the mask bit.
  - start with mask≠0 goes to SELECT, with search origin = slot NUM_PROG-1 so the scan reaches slot 0 first.
  - start with mask=0 goes to DONE.
- RUN:
  - Each instr_retired decrements quantum_left.
  - A retire while quantum_left=1 goes to SAVE.
  - end_program clears mask[cur] and goes to SELECT without a save. end_program takes priority over simultaneous expiry.
- SAVE (1 cycle): table[cur] <= cur_pc, then SELECT.
- SELECT (1 cycle):
  - Picks the first active slot scanning cur+1, cur+2, … with wrap, ending at cur itself.
  - If the only active slot is cur, cur is re-granted.
  - mask=0 goes to DONE.
- GRANT:
  - switch_req=1, new_pc=table[sel], new_id=sel, all registered.
  - Held until switch_ack.
  - On the ack cycle: go to RUN, switch_req=0, quantum_left = quantum register, cur = sel.
- Latency: a retire edge that expires the slice has switch_req high on the 3rd following edge (SAVE, SELECT, GRANT). end_program gives switch_req on the 2nd edge.
- DONE: all_done=1, running=0. A new slot_load plus start re-enters SELECT.
- def_quantum:
  - Accepted in any state.
  - Affects the next slice only; the current quantum_left is untouched.
  - quantum_in=0 is stored as 1.
- slot_load:
  - To an inactive slot it is accepted in any state; the slot joins at the next SELECT.
  - To an active slot it is ignored.
- instr_retired outside RUN is ignored. switch_ack outside GRANT is ignored.
- running=1 only in RUN. quantum_left holds its value outside RUN.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/SAVE/SELECT/GRANT/RUN/DONE);
  - the slot index width function;
  - the DEFAULT_QUANTUM constant, reused by the control unit.
- One sub-module, rr_arbiter_pick: combinational rotate-priority picker.
  - Inputs: mask and origin.
  - Outputs: sel and found.
  - Reusable for other round-robin sharing.

Test Plan:
- Load slots 0,1,2 with PCs 0x10, 0x40, 0x80; quantum 3; start → grant id0/0x10; after 3 retires (cur_pc=0x13) → grant id1/0x40 on the 3rd edge; table[0]=0x13.
- After a full rotation, slot 0 is re-granted with new_pc=0x13 → resume verified.
- end_program on slot 1 in the same cycle as the expiring retire → no save, mask bit 1 cleared, grant id2 on the 2nd edge.
- Single active slot, expiry with cur_pc=0x55 → re-grant same id, new_pc=0x55.
- Withhold switch_ack 5 cycles → switch_req, new_pc and new_id stable throughout; retires are ignored.
- def_quantum=0 mid-slice → current slice unchanged, next slice quantum_left=1.
- End every program → all_done=1.
- Reset asserted during GRANT → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rr_program_scheduler_pkg.sv
// Shared definitions for the round-robin program scheduler.
//   rr_state_e         : scheduler FSM states
//   RR_DEFAULT_QUANTUM : instructions per slice after reset (also used by the control unit)
//   rr_idx_w()         : bit width of a slot index for a given slot count
package rr_program_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAVE   = 3'd1,
        ST_SELECT = 3'd2,
        ST_GRANT  = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } rr_state_e;

    localparam int RR_DEFAULT_QUANTUM = 100;

    // Never narrower than one bit, so a two-slot build still has an index.
    function automatic int rr_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_program_scheduler_arbiter.sv
// rr_arbiter_pick: combinational rotate-priority picker.
// Returns the first set bit of mask_i scanning origin_i+1, origin_i+2, ...
// with wrap-around, ending at origin_i itself.
//   mask_i   : request / active flags, one per slot
//   origin_i : index of the last winner (lowest priority this round)
//   sel_o    : winning index (0 when nothing is found)
//   found_o  : at least one mask bit is set
import rr_program_scheduler_pkg::*;

module rr_arbiter_pick #(
    parameter int N   = 4,
    parameter int IDW = rr_idx_w(N)
) (
    input  logic [N-1:0]   mask_i,
    input  logic [IDW-1:0] origin_i,
    output logic [IDW-1:0] sel_o,
    output logic           found_o
);

    // Rotating scan; the first hit wins and later hits are masked by found_o.
    always_comb begin
        logic [IDW-1:0] idx_v;
        logic           hit_v;
        sel_o   = '0;
        found_o = 1'b0;
        idx_v   = '0;
        hit_v   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx_v   = IDW'((int'(origin_i) + i) % N);
            hit_v   = !found_o && mask_i[idx_v];
            sel_o   = hit_v ? idx_v : sel_o;
            found_o = found_o | mask_i[idx_v];
        end
    end

endmodule

// File: rtl/rr_program_scheduler.sv
// rr_program_scheduler: preemptive round-robin scheduler over NUM_PROG slots.
// Keeps a saved-PC table and an active mask, counts retired instructions
// against a programmable quantum, and hands the PC unit a restore PC via a
// req/ack handshake.
//   clock, reset   : system clock, asynchronous active-low reset
//   slot_load/slot_id/slot_pc : register a start PC and activate a slot
//   start          : begin scheduling from the lowest-index active slot
//   instr_retired  : one pulse per executed instruction
//   def_quantum/quantum_in    : program the quantum for following slices
//   end_program    : running program halted (slot leaves the rotation)
//   cur_pc         : live PC, saved when the running slot is preempted
//   switch_ack     : PC unit has taken new_pc
//   switch_req/new_pc/new_id  : registered switch request to the PC unit
//   running, all_done, active_mask, quantum_left : status
import rr_program_scheduler_pkg::*;

module rr_program_scheduler #(
    parameter int NUM_PROG        = 4,
    parameter int ADDR_W          = 32,
    parameter int QUANTUM_W       = 16,
    parameter int DEFAULT_QUANTUM = RR_DEFAULT_QUANTUM,
    localparam int IDW            = rr_idx_w(NUM_PROG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 slot_load,
    input  logic [IDW-1:0]       slot_id,
    input  logic [ADDR_W-1:0]    slot_pc,
    input  logic                 start,
    input  logic                 instr_retired,
    input  logic                 def_quantum,
    input  logic [QUANTUM_W-1:0] quantum_in,
    input  logic                 end_program,
    input  logic [ADDR_W-1:0]    cur_pc,
    input  logic                 switch_ack,
    output logic                 switch_req,
    output logic [ADDR_W-1:0]    new_pc,
    output logic [IDW-1:0]       new_id,
    output logic                 running,
    output logic                 all_done,
    output logic [NUM_PROG-1:0]  active_mask,
    output logic [QUANTUM_W-1:0] quantum_left
);

    rr_state_e             state_q;
    logic [IDW-1:0]        cur_q;
    logic [NUM_PROG-1:0]   mask_q;
    logic [NUM_PROG-1:0]   mask_d;
    logic [ADDR_W-1:0]     table_q [NUM_PROG];
    logic [QUANTUM_W-1:0]  quantum_q;
    logic [QUANTUM_W-1:0]  quantum_left_q;
    logic                  switch_req_q;
    logic [ADDR_W-1:0]     new_pc_q;
    logic [IDW-1:0]        new_id_q;
    logic                  running_q;
    logic                  all_done_q;

    logic                  load_ok_s;
    logic [NUM_PROG-1:0]   load_bit_s;
    logic [NUM_PROG-1:0]   clear_bit_s;
    logic [NUM_PROG-1:0]   mask_loaded_s;
    logic [IDW-1:0]        pick_sel_s;
    logic                  pick_found_s;

    // A load only takes effect on an in-range slot that is not already active,
    // so a running program's entry point can never be overwritten.
    assign load_ok_s     = slot_load && (int'(slot_id) < NUM_PROG) && !mask_q[slot_id];
    assign load_bit_s    = load_ok_s ? (NUM_PROG'(1) << slot_id) : '0;
    assign clear_bit_s   = (state_q == ST_RUN && end_program) ? (NUM_PROG'(1) << cur_q) : '0;
    assign mask_loaded_s = mask_q | load_bit_s;
    assign mask_d        = mask_loaded_s & ~clear_bit_s;

    rr_arbiter_pick #(
        .N   (NUM_PROG),
        .IDW (IDW)
    ) u_pick (
        .mask_i   (mask_q),
        .origin_i (cur_q),
        .sel_o    (pick_sel_s),
        .found_o  (pick_found_s)
    );

    // Scheduler FSM together with the PC table, mask, quantum and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cur_q          <= '0;
            mask_q         <= '0;
            quantum_q      <= QUANTUM_W'(DEFAULT_QUANTUM);
            quantum_left_q <= '0;
            switch_req_q   <= 1'b0;
            new_pc_q       <= '0;
            new_id_q       <= '0;
            running_q      <= 1'b0;
            all_done_q     <= 1'b0;
            for (int i = 0; i < NUM_PROG; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            mask_q <= mask_d;
            if (def_quantum) begin
                quantum_q <= (quantum_in == '0) ? QUANTUM_W'(1) : quantum_in;
            end
            if (load_ok_s) begin
                table_q[slot_id] <= slot_pc;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Origin at the top slot makes the scan reach slot 0 first.
                        cur_q <= IDW'(NUM_PROG - 1);
                        if (mask_loaded_s != '0) begin
                            state_q    <= ST_SELECT;
                            all_done_q <= 1'b0;
                        end else begin
                            state_q    <= ST_DONE;
                            all_done_q <= 1'b1;
                        end
                    end
                end
                ST_SAVE: begin
                    // cur is active here, so this never collides with a slot load.
                    table_q[cur_q] <= cur_pc;
                    state_q        <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (pick_found_s) begin
                        new_id_q     <= pick_sel_s;
                        new_pc_q     <= table_q[pick_sel_s];
                        switch_req_q <= 1'b1;
                        state_q      <= ST_GRANT;
                    end else begin
                        all_done_q   <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_GRANT: begin
                    if (switch_ack) begin
                        switch_req_q   <= 1'b0;
                        quantum_left_q <= quantum_q;
                        cur_q          <= new_id_q;
                        running_q      <= 1'b1;
                        state_q        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A halt wins over a simultaneous expiry: nothing worth saving.
                    if (end_program) begin
                        running_q <= 1'b0;
                        state_q   <= ST_SELECT;
                    end else if (instr_retired) begin
                        quantum_left_q <= quantum_left_q - QUANTUM_W'(1);
                        if (quantum_left_q == QUANTUM_W'(1)) begin
                            running_q <= 1'b0;
                            state_q   <= ST_SAVE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign switch_req   = switch_req_q;
    assign new_pc       = new_pc_q;
    assign new_id       = new_id_q;
    assign running      = running_q;
    assign all_done     = all_done_q;
    assign active_mask  = mask_q;
    assign quantum_left = quantum_left_q;

endmodule
